tiempo_lectura_rtc: RTL

TIEMPO_LECTURA_RTC -- requirements
Module: tiempo_lectura_rtc

---
 rtl/tiempo_lectura_rtc.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/tiempo_lectura_rtc.sv
// tiempo_lectura_rtc
// Sequences one read cycle on a multiplexed-address/data RTC bus. The cycle
// runs address strobe (ADDR), address hold (AHOLD), read strobe (READ),
// recovery (RECOV) and a one-clock DONE. Each phase length is set by a
// parameter and timed with a 4-bit down-counter.
//
// Parameters:
//   T_AW  - clocks in the address-write strobe phase (1..15)
//   T_GAP - clocks in each recovery gap, AHOLD and RECOV (1..15)
//   T_RD  - clocks in the read strobe phase (1..15)
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   start    in   request one read cycle; only looked at in IDLE
//   addr     in   8-bit register address, latched when start is accepted
//   ad_in    in   8-bit bus input side
//   ad_out   out  8-bit bus output side (latched address)
//   ad_oe    out  1 = ad_out drives the pad
//   CS/RD/WR out  chip select, read strobe, write strobe (all active low)
//   AD       out  address/data select, 0 = address phase
//   data_out out  captured read byte, held until the next capture
//   done     out  one-clock pulse in the DONE state
//   busy     out  high in every state except IDLE
//
// Build option:
//   RTC_BCD2BIN_EN - when defined, the captured byte is converted from
//                    packed BCD to binary (tens*10+units). Nibbles above 9
//                    are not checked or saturated.
//
// All outputs are registers. They are decoded from the next state, so
// they change on the same edge as the state register.

module tiempo_lectura_rtc #(
  parameter int T_AW  = 4,
  parameter int T_GAP = 2,
  parameter int T_RD  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       AD,
  output logic [7:0] data_out,
  output logic       done,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_AHOLD = 3'd2,
    S_READ  = 3'd3,
    S_RECOV = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // The timer is loaded with (length - 1) on phase entry. The phase ends
  // on the edge where the timer is zero.
  localparam logic [3:0] AW_LAST  = 4'(T_AW - 1);
  localparam logic [3:0] GAP_LAST = 4'(T_GAP - 1);
  localparam logic [3:0] RD_LAST  = 4'(T_RD - 1);

`ifdef RTC_BCD2BIN_EN
  // Packed BCD to binary: tens*10 + units, computed as tens*8 + tens*2 + units.
  // The largest result is 15*10 + 15 = 165, so 8 bits are enough.
  function automatic logic [7:0] bcd2bin(input logic [7:0] bcd);
    logic [7:0] tens;
    tens = {4'd0, bcd[7:4]};
    return (tens << 3) + (tens << 1) + {4'd0, bcd[3:0]};
  endfunction
`endif

  state_t     state_r, state_s;
  logic [3:0] timer_r, timer_s;
  logic       capture_s;
  logic [7:0] capture_val_s;
  logic       cs_s, rd_s, wr_s, ad_s, oe_s, done_s, busy_s;

  // Next-state and phase-timer logic.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_ADDR;
          timer_s = AW_LAST;
        end else begin
          state_s = S_IDLE;
          timer_s = 4'd0;
        end
      end
      S_ADDR: begin
        if (timer_r == 4'd0) begin
          state_s = S_AHOLD;
          timer_s = GAP_LAST;
        end else begin
          timer_s = timer_r - 4'd1;
        end
      end
      S_AHOLD: begin
        if (timer_r == 4'd0) begin
          state_s = S_READ;
          timer_s = RD_LAST;
        end else begin
          timer_s = timer_r - 4'd1;
        end
      end
      S_READ: begin
        if (timer_r == 4'd0) begin
          state_s = S_RECOV;
          timer_s = GAP_LAST;
        end else begin
          timer_s = timer_r - 4'd1;
        end
      end
      S_RECOV: begin
        if (timer_r == 4'd0) begin
          state_s = S_DONE;
          timer_s = 4'd0;
        end else begin
          timer_s = timer_r - 4'd1;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
        timer_s = 4'd0;
      end
      default: begin
        state_s = S_IDLE;
        timer_s = 4'd0;
      end
    endcase
  end

  // Decode bus controls for the state being entered. This keeps RD and WR
  // from being low together, and keeps ad_oe from being high while RD is low.
  always_comb begin
    cs_s   = 1'b1;
    rd_s   = 1'b1;
    wr_s   = 1'b1;
    ad_s   = 1'b1;
    oe_s   = 1'b0;
    done_s = 1'b0;
    busy_s = 1'b1;
    case (state_s)
      S_IDLE:  busy_s = 1'b0;
      S_ADDR: begin
        cs_s = 1'b0;
        wr_s = 1'b0;
        ad_s = 1'b0;
        oe_s = 1'b1;
      end
      S_AHOLD: oe_s = 1'b1;
      S_READ: begin
        cs_s = 1'b0;
        rd_s = 1'b0;
      end
      S_RECOV: oe_s = 1'b0;
      S_DONE:  done_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Capture on the edge that ends the last READ clock, while RD is still low.
  always_comb begin
    capture_s = (state_r == S_READ) && (timer_r == 4'd0);
`ifdef RTC_BCD2BIN_EN
    capture_val_s = bcd2bin(ad_in);
`else
    capture_val_s = ad_in;
`endif
  end

  // State, timer and registered outputs. Reset forces everything idle
  // immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= S_IDLE;
      timer_r  <= 4'd0;
      ad_out   <= 8'h00;
      ad_oe    <= 1'b0;
      CS       <= 1'b1;
      RD       <= 1'b1;
      WR       <= 1'b1;
      AD       <= 1'b1;
      data_out <= 8'h00;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      ad_oe   <= oe_s;
      CS      <= cs_s;
      RD      <= rd_s;
      WR      <= wr_s;
      AD      <= ad_s;
      done    <= done_s;
      busy    <= busy_s;
      if ((state_r == S_IDLE) && start) begin
        ad_out <= addr;
      end else begin
        ad_out <= ad_out;
      end
      if (capture_s) begin
        data_out <= capture_val_s;
      end else begin
        data_out <= data_out;
      end
    end
  end

endmodule
